// File: rtl/act_pkg.sv
// Shared types and constants for the activation unit: FSM states, lane widths
// and the int8 saturation bounds.
package act_pkg;

  localparam int LANES          = 8;
  localparam int ACC_W          = 16;
  localparam int OUT_W          = 8;
  localparam int SHIFT_W        = 4;
  localparam int DATA_W         = 64;
  localparam int LANES_PER_BEAT = DATA_W / ACC_W;
  localparam int ROW_W          = 8;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

endpackage

// File: rtl/act_lane.sv
// One output lane: rounding arithmetic right shift, optional ReLU, and
// saturation of a signed 16-bit partial sum down to int8.
module act_lane
  import act_pkg::*;
(
  input  logic [ACC_W-1:0]   x,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu_en,
  output logic [OUT_W-1:0]   y
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(INT8_MAX);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(INT8_MIN);

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] scaled;

  // The extra bit keeps x + 2^(s-1) from overflowing even for 0x7FFF at s=15.
  always_comb begin
    ext  = $signed({x[ACC_W-1], x});
    bias = '0;
    if (shift != '0) begin
      bias = (ACC_W+1)'(1) <<< (shift - SHIFT_W'(1));
    end
    rounded = ext + bias;
    scaled  = rounded >>> shift;

    y = scaled[OUT_W-1:0];
    if (relu_en && scaled[ACC_W]) begin
      y = '0;
    end else if (scaled > SAT_MAX) begin
      y = SAT_MAX[OUT_W-1:0];
    end else if (scaled < SAT_MIN) begin
      y = SAT_MIN[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/activation_unit.sv
// Collects two 64-bit partial-sum beats per row from the systolic array,
// requantises the eight lanes to int8 and presents one packed row per pulse.
module activation_unit
  import act_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start_array,
  input  logic [ROW_W-1:0]   num_input,
  input  logic               relu_en,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               array_valid,
  input  logic [DATA_W-1:0]  array_data,
  output logic [DATA_W-1:0]  activations,
  output logic               activation_ready,
  output logic               activated,
  output logic               act_err
);

  state_t state;
  state_t next_state;

  logic [ROW_W-1:0]         rows;
  logic [DATA_W-1:0]        lo_beat;
  logic                     relu_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic [LANES*ACC_W-1:0]   row_data;
  logic [LANES*OUT_W-1:0]   packed_row;
  logic                     start_ok;
  logic                     lo_beat_en;
  logic                     hi_beat_en;
  logic                     proto_err;

  assign start_ok   = start_array && (state == IDLE);
  assign lo_beat_en = array_valid && (state == LO);
  assign hi_beat_en = array_valid && (state == HI);
  assign proto_err  = (start_array && (state != IDLE)) ||
                      (array_valid && ((state == IDLE) || (state == DONE)));

  // Upper lanes come straight from the HI beat so the row registers in one cycle.
  assign row_data = {array_data, lo_beat};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane u_lane (
      .x       (row_data[g*ACC_W +: ACC_W]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .y       (packed_row[g*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_array) begin
          next_state = (num_input != '0) ? LO : DONE;
        end
      end
      LO: begin
        if (array_valid) begin
          next_state = HI;
        end
      end
      HI: begin
        if (array_valid) begin
          next_state = (rows == ROW_W'(1)) ? DONE : LO;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // activated is registered off DONE so it always trails the last row by a cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rows             <= '0;
      lo_beat          <= '0;
      relu_q           <= 1'b0;
      shift_q          <= '0;
      activations      <= '0;
      activation_ready <= 1'b0;
      activated        <= 1'b0;
      act_err          <= 1'b0;
    end else begin
      activation_ready <= hi_beat_en;
      activated        <= (state == DONE);
      if (start_ok) begin
        rows    <= num_input;
        relu_q  <= relu_en;
        shift_q <= shift;
      end
      if (lo_beat_en) begin
        lo_beat <= array_data;
      end
      if (hi_beat_en) begin
        activations <= packed_row;
        rows        <= rows - ROW_W'(1);
      end
      if (proto_err) begin
        act_err <= 1'b1;
      end else if (start_ok) begin
        act_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: a vector table of single-row batches
// plus hand-written sequences for multi-row, error, reset and empty batches.
module tb_activation_unit;
  import act_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start_array;
  logic [7:0]  num_input;
  logic        relu_en;
  logic [3:0]  shift;
  logic        array_valid;
  logic [63:0] array_data;
  logic [63:0] activations;
  logic        activation_ready;
  logic        activated;
  logic        act_err;

  activation_unit dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start_array      (start_array),
    .num_input        (num_input),
    .relu_en          (relu_en),
    .shift            (shift),
    .array_valid      (array_valid),
    .array_data       (array_data),
    .activations      (activations),
    .activation_ready (activation_ready),
    .activated        (activated),
    .act_err          (act_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        relu;
    logic [3:0]  shift;
    logic [63:0] lo;
    logic [63:0] hi;
    logic [63:0] expected;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int rdy_cnt;
  int done_cnt;
  int last_rdy_cycle;
  int done_cycle;
  int beat_cycle;
  int start_cycle;
  int overlap;
  logic [63:0] last_act;

  // Time only advances here, so pulse counting never misses a cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (activation_ready) begin
      rdy_cnt++;
      last_rdy_cycle = cycle;
      last_act = activations;
    end
    if (activated) begin
      done_cnt++;
      done_cycle = cycle;
      if (activation_ready) overlap++;
    end
  endtask

  task automatic clear_mon();
    rdy_cnt = 0;
    done_cnt = 0;
    overlap = 0;
    last_rdy_cycle = -100;
    done_cycle = -100;
    last_act = '0;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic relu, input logic [3:0] sh,
                                input logic [63:0] lo, input logic [63:0] hi);
    clear_mon();
    start_array = 1'b1;
    num_input   = 8'd1;
    relu_en     = relu;
    shift       = sh;
    tick();
    start_array = 1'b0;
    array_valid = 1'b1;
    array_data  = lo;
    tick();
    array_data  = hi;
    tick();
    beat_cycle  = cycle;
    array_valid = 1'b0;
    array_data  = '0;
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{"passthru", 1'b0, 4'd0, 64'h0004_0003_0002_0001,
                64'h0008_0007_0006_0005, 64'h0807_0605_0403_0201};
    vecs[1] = '{"round_sat", 1'b0, 4'd4, 64'h8000_7FFF_0017_0018,
                64'h0028_FFE8_0008_FFFF, 64'h03FF_0100_807F_0102};
    vecs[2] = '{"relu_on", 1'b1, 4'd0, 64'h0080_FF7F_FFFB_0005,
                64'h0000_FFFF_007F_FF80, 64'h0000_7F00_7F00_0005};
    vecs[3] = '{"relu_off", 1'b0, 4'd0, 64'h0080_FF7F_FFFB_0005,
                64'h0000_FFFF_007F_FF80, 64'h00FF_7F80_7F80_FB05};
    vecs[4] = '{"shift15", 1'b0, 4'd15, 64'h8000_C000_3FFF_4000,
                64'hFFFF_0000_BFFF_7FFF, 64'h0000_FF01_FF00_0001};
    vecs[5] = '{"shift1_relu", 1'b1, 4'd1, 64'h0001_00FF_FFFD_0003,
                64'h0000_0000_0000_0000, 64'h0000_0000_017F_0002};

    n_rst = 1'b0;
    start_array = 1'b0;
    num_input = '0;
    relu_en = 1'b0;
    shift = '0;
    array_valid = 1'b0;
    array_data = '0;
    clear_mon();

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_activations", activations, 64'd0);
    check_output("reset_ready", 64'(activation_ready), 64'd0);
    check_output("reset_activated", 64'(activated), 64'd0);
    check_output("reset_err", 64'(act_err), 64'd0);
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].relu, vecs[i].shift, vecs[i].lo, vecs[i].hi);
      check_output({vecs[i].name, "_value"}, last_act, vecs[i].expected);
      check_output({vecs[i].name, "_latency"}, 64'(last_rdy_cycle), 64'(beat_cycle));
      check_output({vecs[i].name, "_ready_cnt"}, 64'(rdy_cnt), 64'd1);
      check_output({vecs[i].name, "_done_cycle"}, 64'(done_cycle), 64'(beat_cycle + 1));
      check_output({vecs[i].name, "_err"}, 64'(act_err), 64'd0);
    end

    // Three-row batch with idle gaps inside and between rows.
    clear_mon();
    start_array = 1'b1;
    num_input = 8'd3;
    relu_en = 1'b0;
    shift = 4'd0;
    tick();
    start_array = 1'b0;
    for (int r = 0; r < 3; r++) begin
      array_valid = 1'b1;
      array_data = {16'(8*r+4), 16'(8*r+3), 16'(8*r+2), 16'(8*r+1)};
      tick();
      if (r == 1) begin
        array_valid = 1'b0;
        tick();
        tick();
      end
      array_valid = 1'b1;
      array_data = {16'(8*r+8), 16'(8*r+7), 16'(8*r+6), 16'(8*r+5)};
      tick();
      array_valid = 1'b0;
      if (r != 2) tick();
    end
    repeat (3) tick();
    check_output("multi_ready_cnt", 64'(rdy_cnt), 64'd3);
    check_output("multi_done_cnt", 64'(done_cnt), 64'd1);
    check_output("multi_last_row", last_act, 64'h1817_1615_1413_1211);
    check_output("multi_done_after", 64'(done_cycle), 64'(last_rdy_cycle + 1));
    check_output("multi_overlap", 64'(overlap), 64'd0);

    // Beat while idle is dropped and flagged.
    clear_mon();
    array_valid = 1'b1;
    array_data = 64'h1111_2222_3333_4444;
    tick();
    array_valid = 1'b0;
    tick();
    tick();
    check_output("idle_beat_err", 64'(act_err), 64'd1);
    check_output("idle_beat_no_row", 64'(rdy_cnt + done_cnt), 64'd0);

    // Accepted start clears the error; a start in LO is ignored but flagged.
    clear_mon();
    start_array = 1'b1;
    num_input = 8'd1;
    relu_en = 1'b0;
    shift = 4'd0;
    tick();
    check_output("start_clears_err", 64'(act_err), 64'd0);
    num_input = 8'd5;
    relu_en = 1'b1;
    shift = 4'd4;
    tick();
    start_array = 1'b0;
    check_output("start_in_lo_err", 64'(act_err), 64'd1);
    array_valid = 1'b1;
    array_data = vecs[0].lo;
    tick();
    array_data = vecs[0].hi;
    tick();
    array_valid = 1'b0;
    repeat (3) tick();
    check_output("start_in_lo_value", last_act, vecs[0].expected);
    check_output("start_in_lo_ready", 64'(rdy_cnt), 64'd1);
    check_output("start_in_lo_done", 64'(done_cnt), 64'd1);

    // Start with a simultaneous beat, then a stray beat while in DONE.
    clear_mon();
    start_array = 1'b1;
    num_input = 8'd1;
    relu_en = 1'b0;
    shift = 4'd0;
    array_valid = 1'b1;
    array_data = 64'h7F7F_7F7F_7F7F_7F7F;
    tick();
    start_array = 1'b0;
    check_output("start_and_beat_err", 64'(act_err), 64'd1);
    array_data = vecs[0].lo;
    tick();
    array_data = vecs[0].hi;
    tick();
    array_data = 64'h0101_0101_0101_0101;
    tick();
    array_valid = 1'b0;
    repeat (2) tick();
    check_output("start_and_beat_value", last_act, vecs[0].expected);
    check_output("beat_in_done_ready", 64'(rdy_cnt), 64'd1);
    check_output("beat_in_done_done", 64'(done_cnt), 64'd1);
    check_output("beat_in_done_err", 64'(act_err), 64'd1);

    // Asynchronous reset in the middle of a two-row batch.
    clear_mon();
    start_array = 1'b1;
    num_input = 8'd2;
    tick();
    start_array = 1'b0;
    array_valid = 1'b1;
    array_data = vecs[0].lo;
    tick();
    array_valid = 1'b0;
    start_array = 1'b1;
    tick();
    start_array = 1'b0;
    check_output("pre_reset_err", 64'(act_err), 64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check_output("midreset_activations", activations, 64'd0);
    check_output("midreset_err", 64'(act_err), 64'd0);
    check_output("midreset_flags", 64'({activation_ready, activated}), 64'd0);
    #2;
    n_rst = 1'b1;
    repeat (4) tick();
    check_output("midreset_no_done", 64'(done_cnt + rdy_cnt), 64'd0);

    // Empty batch: a single activated pulse and no rows.
    clear_mon();
    start_array = 1'b1;
    num_input = 8'd0;
    tick();
    start_cycle = cycle;
    start_array = 1'b0;
    repeat (3) tick();
    check_output("empty_done_cnt", 64'(done_cnt), 64'd1);
    check_output("empty_ready_cnt", 64'(rdy_cnt), 64'd0);
    check_output("empty_done_cycle", 64'(done_cycle), 64'(start_cycle + 1));

    // Full 255-row batch exercises the counter without wrap.
    clear_mon();
    start_array = 1'b1;
    num_input = 8'd255;
    relu_en = 1'b0;
    shift = 4'd0;
    tick();
    start_array = 1'b0;
    for (int r = 0; r < 255; r++) begin
      array_valid = 1'b1;
      array_data = {4{16'(r)}};
      tick();
      tick();
    end
    array_valid = 1'b0;
    repeat (3) tick();
    check_output("rows255_ready_cnt", 64'(rdy_cnt), 64'd255);
    check_output("rows255_done_cnt", 64'(done_cnt), 64'd1);
    check_output("rows255_last_row", last_act, 64'h7F7F_7F7F_7F7F_7F7F);
    check_output("rows255_done_after", 64'(done_cycle), 64'(last_rdy_cycle + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
- Sits between the systolic array output and the SRAM controller's activation interface; it is the producer of `activations`, `activation_ready` and `activated`.
- Collects 16-bit signed partial sums from the array, two 64-bit beats per output row (8 lanes).
- Per lane: requantises by a rounding arithmetic shift, optionally applies ReLU, and saturates to int8.
- Packs each row into one 64-bit word for the controller.

Parameters:
- LANES, 8, output lanes per row; fixed to 64/8.
- ACC_W, 16, partial-sum width per lane; 4 lanes per input beat.
- SHIFT_W, 4, width of the requantisation shift field.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start_array  in  1  one-cycle pulse; begins a new output batch
- num_input  in  8  rows expected in the batch, sampled on an accepted start_array
- relu_en  in  1  ReLU enable, sampled on an accepted start_array
- shift  in  SHIFT_W  right-shift amount 0..15, sampled on an accepted start_array
- array_valid  in  1  array_data holds a valid beat this cycle
- array_data  in  64  4 x int16 partial sums; lane k at bits [16k+15:16k]
- activations  out  64  8 x int8 packed row; lane i at bits [8i+7:8i]
- activation_ready  out  1  one-cycle pulse; activations valid this cycle
- activated  out  1  one-cycle pulse; batch complete
- act_err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, n_rst=0):
  - state IDLE.
  - activations=0, activation_ready=0, activated=0, act_err=0.
  - Row counter, low-beat register and sampled config all cleared.
  - Reset mid-batch abandons the batch silently, with no activated pulse.
- States:
  - IDLE:
    - start_array with num_input>0: latch rows=num_input, relu_en, shift; clear act_err; go LO.
    - start_array with num_input==0: go DONE.
  - LO: on array_valid, capture array_data as lanes 0-3; go HI.
  - HI: on array_valid, the beat is lanes 4-7.
    - Compute all 8 lanes and register them into activations.
    - activation_ready=1 in the next cycle (latency 1 from the HI beat).
    - Decrement rows; if rows was 1 go DONE, else go LO.
  - DONE:
    - activated=1 for exactly one cycle, then IDLE.
    - activated is asserted in the cycle after the final activation_ready, never in the same cycle.
- No backpressure: every produced row is presented exactly once. activations holds its value until the next row is produced.
- Lane arithmetic, with x = signed 16-bit lane value and s = the latched shift:
  - Sign-extend x to 17 bits. If s>0, add 1<<(s-1) (round half up). Arithmetic-shift right by s.
  - If relu_en and the result <0, the result becomes 0.
  - Saturate to [-128, 127]; emit two's-complement 8 bits.
  - s=0 is pass-through with saturation only.
- Errors (each sets act_err; act_err clears only on reset or the next accepted start):
  - start_array outside IDLE: ignored; the batch in progress continues unaffected.
  - array_valid in IDLE or DONE: the beat is dropped.
- Simultaneous start_array and array_valid in IDLE: start is accepted; the beat is dropped and flagged as an error.
- Row counter is 8 bits; num_input=255 produces 255 rows with no wrap.
- relu_en and shift changes mid-batch have no effect.

Decomposition:
- Package act_pkg:
  - state enum (IDLE, LO, HI, DONE)
  - LANES, ACC_W, OUT_W=8
  - INT8_MAX=127, INT8_MIN=-128
- Sub-module act_lane: purely combinational requantise/ReLU/saturate for one lane (inputs x, shift, relu_en; output int8).
  - Instantiated 8 times under activation_unit.
  - The FSM, counter and output register stay in activation_unit.

Test Plan:
- Single row:
  - Stimulus: num_input=1, shift=0, relu_en=0; beats 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005.
  - Response: activations=0x0807060504030201 with activation_ready for one cycle after the HI beat; activated one cycle later.
- Rounding and saturation:
  - Stimulus: shift=4, lanes 0x0018 (24) and 0x0017 (23), plus lanes 0x7FFF and 0x8000.
  - Response: 24→2, 23→1, 0x7FFF→0x7F, 0x8000→0x80.
- ReLU: relu_en=1, shift=0, lane 0xFFFB (-5) -> 0x00; with relu_en=0 the same lane -> 0xFB.
- Multi-row batch: num_input=3 with 6 beats, some separated by idle cycles -> exactly 3 activation_ready pulses, then a single activated pulse; state returns to IDLE.
- Errors:
  - array_valid in IDLE -> act_err=1, no output.
  - start_array while in LO -> act_err=1 and the batch still completes.
  - The next accepted start clears act_err.
- Reset and empty batch:
  - Assert n_rst after one beat of a 2-row batch -> all outputs 0, no activated pulse.
  - num_input=0 -> activated pulses once with no activation_ready.
